// File: rtl/apb_timer_mc.sv
// Purpose : multi-channel APB timer, NUM_CH prescaled up-counters with auto-reload,
//           one-shot mode, sticky W1C event flags and a merged interrupt.
// Latency : writes land on the access edge, reads are registered on the setup edge,
//           IRQ outputs are combinational from flops.
// Backpressure: none, PREADY is tied high (zero wait states).
//
// Ports:
//   PCLK, PRESETn          clock, synchronous active-low reset
//   PSEL/PENABLE/PWRITE    APB control
//   PADDR, PWDATA          APB address (only [8:0] decoded) and write data
//   PRDATA, PREADY         registered read data, always-ready
//   PSLVERR                error during the access phase of an unmapped address
//   TIM_IRQ, TIM_IRQ_VEC   merged and per-channel interrupts (STAT & IE)
module apb_timer_mc #(
    parameter int NUM_CH = 2,
    parameter int CNT_W  = 16,
    parameter int PSC_W  = 8
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [31:0]       PADDR,
    input  logic [31:0]       PWDATA,
    output logic [31:0]       PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    output logic              TIM_IRQ,
    output logic [NUM_CH-1:0] TIM_IRQ_VEC
);

    localparam logic [31:0] VER_VAL = {16'h0001, 8'(NUM_CH), 8'(CNT_W)};

    // Per-channel state
    logic [NUM_CH-1:0]            en;
    logic [NUM_CH-1:0]            ie;
    logic [NUM_CH-1:0]            os;
    logic [NUM_CH-1:0][PSC_W-1:0] psc;
    logic [NUM_CH-1:0][CNT_W-1:0] arr;
    logic [NUM_CH-1:0][PSC_W-1:0] pre;
    logic [NUM_CH-1:0][CNT_W-1:0] cnt;
    logic [NUM_CH-1:0]            stat;
    logic                         err_q;

    // Address decode
    logic [8:0]  addr;
    logic [3:0]  ch_idx;
    logic        is_ch;
    logic        is_stat;
    logic        is_ver;
    logic        mapped;
    logic        wr_acc;
    logic        rd_setup;
    logic [31:0] rd_mux;

    assign addr     = PADDR[8:0];
    assign ch_idx   = addr[7:4];
    assign is_ch    = !addr[8] && ({28'd0, ch_idx} < 32'(NUM_CH));
    assign is_stat  = (addr == 9'h100);
    assign is_ver   = (addr == 9'h104);
    assign mapped   = (addr[1:0] == 2'b00) && (is_ch || is_stat || is_ver);
    assign wr_acc   = PSEL && PENABLE && PWRITE && mapped;
    assign rd_setup = PSEL && !PENABLE && !PWRITE;

    // Prescaler wrap and counter wrap. Using >= rather than == lets a PSC or ARR
    // write below the current value take effect on the very next tick.
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] evt;
    logic [NUM_CH-1:0] stat_clr;

    always_comb begin
        tick     = '0;
        evt      = '0;
        stat_clr = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            tick[c] = en[c] && (pre[c] >= psc[c]);
            evt[c]  = tick[c] && (cnt[c] >= arr[c]);
        end
        if (wr_acc && is_stat) begin
            stat_clr = PWDATA[NUM_CH-1:0];
        end
    end

    always_comb begin
        rd_mux = '0;
        if (is_ch) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (ch_idx == 4'(c)) begin
                    case (addr[3:2])
                        2'd0:    rd_mux = {29'd0, os[c], ie[c], en[c]};
                        2'd1:    rd_mux = 32'(psc[c]);
                        2'd2:    rd_mux = 32'(arr[c]);
                        default: rd_mux = 32'(cnt[c]);
                    endcase
                end
            end
        end else if (is_stat) begin
            rd_mux = 32'(stat);
        end else if (is_ver) begin
            rd_mux = VER_VAL;
        end
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            en     <= '0;
            ie     <= '0;
            os     <= '0;
            psc    <= '0;
            arr    <= '0;
            pre    <= '0;
            cnt    <= '0;
            stat   <= '0;
            PRDATA <= '0;
            err_q  <= 1'b0;
        end else begin
            if (rd_setup) begin
                PRDATA <= mapped ? rd_mux : 32'd0;
            end
            // Error status is captured in the setup phase and only shown in the access phase.
            if (PSEL && !PENABLE) begin
                err_q <= !mapped;
            end

            for (int c = 0; c < NUM_CH; c++) begin
                if (en[c]) begin
                    if (tick[c]) begin
                        pre[c] <= '0;
                        if (evt[c]) begin
                            cnt[c] <= '0;
                            if (os[c]) begin
                                en[c] <= 1'b0;
                            end
                        end else begin
                            cnt[c] <= cnt[c] + CNT_W'(1);
                        end
                    end else begin
                        pre[c] <= pre[c] + PSC_W'(1);
                    end
                end

                // Bus writes come after the counting logic so a CTRL write
                // overrides a same-edge one-shot auto-clear.
                if (wr_acc && is_ch && (ch_idx == 4'(c))) begin
                    case (addr[3:2])
                        2'd0: begin
                            en[c] <= PWDATA[0];
                            ie[c] <= PWDATA[1];
                            os[c] <= PWDATA[2];
                            if (!en[c] && PWDATA[0]) begin
                                pre[c] <= '0;
                                cnt[c] <= '0;
                            end
                        end
                        2'd1:    psc[c] <= PWDATA[PSC_W-1:0];
                        2'd2:    arr[c] <= PWDATA[CNT_W-1:0];
                        default: ; // CNT is read-only
                    endcase
                end
            end

            // Hardware set wins over a same-edge write-1-to-clear.
            stat <= (stat & ~stat_clr) | evt;
        end
    end

    assign PREADY      = 1'b1;
    assign PSLVERR     = PSEL && PENABLE && err_q;
    assign TIM_IRQ_VEC = stat & ie;
    assign TIM_IRQ     = |TIM_IRQ_VEC;

    logic unused_bits;
    assign unused_bits = ^{PADDR[31:9], PWDATA};

endmodule

// File: tb/tb_apb_timer_mc.sv
// Purpose : directed self-check of apb_timer_mc (register map, bus errors, timing corners).
// Latency : checks sampled 1 ns after the active edge or mid access phase.
// Backpressure: PREADY is always 1, so each APB access is exactly two cycles.
module tb_apb_timer_mc;

    logic        PCLK = 1'b0;
    logic        PRESETn = 1'b0;
    logic        PSEL = 1'b0;
    logic        PENABLE = 1'b0;
    logic        PWRITE = 1'b0;
    logic [31:0] PADDR = '0;
    logic [31:0] PWDATA = '0;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    logic        TIM_IRQ;
    logic [1:0]  TIM_IRQ_VEC;

    int total = 0;
    int bad   = 0;

    apb_timer_mc #(.NUM_CH(2), .CNT_W(16), .PSC_W(8)) dut (
        .PCLK        (PCLK),
        .PRESETn     (PRESETn),
        .PSEL        (PSEL),
        .PENABLE     (PENABLE),
        .PWRITE      (PWRITE),
        .PADDR       (PADDR),
        .PWDATA      (PWDATA),
        .PRDATA      (PRDATA),
        .PREADY      (PREADY),
        .PSLVERR     (PSLVERR),
        .TIM_IRQ     (TIM_IRQ),
        .TIM_IRQ_VEC (TIM_IRQ_VEC)
    );

    always #5 PCLK = ~PCLK;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic edges(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge PCLK);
        end
        #1;
    endtask

    // Called 1 ns after an edge; returns 1 ns after the access edge.
    task automatic apb_write(input logic [31:0] a, input logic [31:0] d, output logic err);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        #2;
        err = PSLVERR;
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [31:0] a, output logic [31:0] d, output logic err);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        #2;
        d   = PRDATA;
        err = PSLVERR;
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        bit          exp_err;
    } vec_t;

    vec_t vecs[18];

    initial begin
        logic        e;
        logic [31:0] d;
        logic [31:0] cnt_exp[6];

        vecs[0]  = '{1'b0, 32'h104, 32'h0,        32'h0001_0210, 1'b0};
        vecs[1]  = '{1'b0, 32'h020, 32'h0,        32'h0,         1'b1};
        vecs[2]  = '{1'b0, 32'h108, 32'h0,        32'h0,         1'b1};
        vecs[3]  = '{1'b1, 32'h00C, 32'h1234,     32'h0,         1'b0};
        vecs[4]  = '{1'b0, 32'h00C, 32'h0,        32'h0,         1'b0};
        vecs[5]  = '{1'b1, 32'h004, 32'hFFFF_FFAB, 32'h0,        1'b0};
        vecs[6]  = '{1'b0, 32'h004, 32'h0,        32'h0000_00AB, 1'b0};
        vecs[7]  = '{1'b1, 32'h008, 32'hFFFF_1234, 32'h0,        1'b0};
        vecs[8]  = '{1'b0, 32'h008, 32'h0,        32'h0000_1234, 1'b0};
        vecs[9]  = '{1'b1, 32'h010, 32'hFFFF_FFF8, 32'h0,        1'b0};
        vecs[10] = '{1'b0, 32'h010, 32'h0,        32'h0,         1'b0};
        vecs[11] = '{1'b1, 32'h014, 32'h5,        32'h0,         1'b0};
        vecs[12] = '{1'b0, 32'h014, 32'h0,        32'h5,         1'b0};
        vecs[13] = '{1'b1, 32'h006, 32'h77,       32'h0,         1'b1};
        vecs[14] = '{1'b0, 32'h004, 32'h0,        32'h0000_00AB, 1'b0};
        vecs[15] = '{1'b1, 32'h030, 32'h1,        32'h0,         1'b1};
        vecs[16] = '{1'b1, 32'h104, 32'hDEAD_BEEF, 32'h0,        1'b0};
        vecs[17] = '{1'b0, 32'h104, 32'h0,        32'h0001_0210, 1'b0};

        // Power-on reset
        edges(3);
        chk("rst_prdata", PRDATA, 32'h0);
        chk("rst_irq", {31'd0, TIM_IRQ}, 32'h0);
        chk("rst_pslverr", {31'd0, PSLVERR}, 32'h0);
        chk("pready", {31'd0, PREADY}, 32'h1);
        PRESETn = 1'b1;
        edges(1);

        // Register map and bus errors
        for (int i = 0; i < 18; i++) begin
            if (vecs[i].wr) begin
                apb_write(vecs[i].addr, vecs[i].wdata, e);
                chk($sformatf("vec%0d_werr", i), {31'd0, e}, {31'd0, vecs[i].exp_err});
            end else begin
                apb_read(vecs[i].addr, d, e);
                chk($sformatf("vec%0d_rdata", i), d, vecs[i].exp_rdata);
                chk($sformatf("vec%0d_rerr", i), {31'd0, e}, {31'd0, vecs[i].exp_err});
            end
        end

        // Periodic ch0: PSC=0 ARR=4, events at E+5, E+10
        apb_write(32'h004, 32'd0, e);
        apb_write(32'h008, 32'd4, e);
        apb_write(32'h000, 32'h3, e);
        edges(4);
        chk("per_irq_E4", {31'd0, TIM_IRQ}, 32'h0);
        edges(1);
        chk("per_irq_E5", {31'd0, TIM_IRQ}, 32'h1);
        chk("per_vec_E5", {30'd0, TIM_IRQ_VEC}, 32'h1);
        apb_write(32'h100, 32'h1, e);
        chk("per_irq_w1c", {31'd0, TIM_IRQ}, 32'h0);
        edges(2);
        chk("per_irq_E9", {31'd0, TIM_IRQ}, 32'h0);
        edges(1);
        chk("per_irq_E10", {31'd0, TIM_IRQ}, 32'h1);

        // CNT sequence: back-to-back reads sample the count after E, E+2, ... E+10
        apb_write(32'h000, 32'h0, e);
        apb_write(32'h100, 32'h1, e);
        apb_write(32'h000, 32'h3, e);
        cnt_exp = '{32'd0, 32'd2, 32'd4, 32'd1, 32'd3, 32'd0};
        for (int i = 0; i < 6; i++) begin
            apb_read(32'h00C, d, e);
            chk($sformatf("cnt_seq%0d", i), d, cnt_exp[i]);
        end

        // Collision: W1C lands on the same edge ch0 sets STAT[0]; IE=0
        apb_write(32'h000, 32'h0, e);
        apb_write(32'h100, 32'h1, e);
        apb_write(32'h000, 32'h1, e);
        edges(3);
        apb_write(32'h100, 32'h1, e);
        chk("col_irq", {31'd0, TIM_IRQ}, 32'h0);
        chk("col_vec", {30'd0, TIM_IRQ_VEC}, 32'h0);
        apb_read(32'h100, d, e);
        chk("col_stat", d, 32'h1);

        // Dynamic ARR: PSC=1 ARR=20, CNT reaches 8 at E+16, ARR=3 written at E+17
        apb_write(32'h000, 32'h0, e);
        apb_write(32'h100, 32'h1, e);
        apb_write(32'h004, 32'd1, e);
        apb_write(32'h008, 32'd20, e);
        apb_write(32'h000, 32'h3, e);
        edges(15);
        apb_write(32'h008, 32'd3, e);
        chk("darr_irq_E17", {31'd0, TIM_IRQ}, 32'h0);
        edges(1);
        chk("darr_irq_E18", {31'd0, TIM_IRQ}, 32'h1);
        apb_write(32'h100, 32'h1, e);
        edges(5);
        chk("darr_irq_E25", {31'd0, TIM_IRQ}, 32'h0);
        edges(1);
        chk("darr_irq_E26", {31'd0, TIM_IRQ}, 32'h1);

        // One-shot ch1: PSC=3 ARR=2, event at E+12 then stop
        apb_write(32'h000, 32'h0, e);
        apb_write(32'h100, 32'h3, e);
        apb_write(32'h014, 32'd3, e);
        apb_write(32'h018, 32'd2, e);
        apb_write(32'h010, 32'h7, e);
        edges(11);
        chk("os_vec_E11", {30'd0, TIM_IRQ_VEC}, 32'h0);
        edges(1);
        chk("os_vec_E12", {30'd0, TIM_IRQ_VEC}, 32'h2);
        chk("os_irq_E12", {31'd0, TIM_IRQ}, 32'h1);
        apb_read(32'h010, d, e);
        chk("os_ctrl", d, 32'h6);
        apb_read(32'h01C, d, e);
        chk("os_cnt", d, 32'h0);
        apb_write(32'h100, 32'h2, e);
        edges(50);
        chk("os_vec_quiet", {30'd0, TIM_IRQ_VEC}, 32'h0);
        apb_read(32'h100, d, e);
        chk("os_stat_quiet", d, 32'h0);

        // Reset mid-count with STAT pending
        apb_write(32'h004, 32'd0, e);
        apb_write(32'h008, 32'd2, e);
        apb_write(32'h000, 32'h3, e);
        edges(10);
        chk("pre_rst_irq", {31'd0, TIM_IRQ}, 32'h1);
        apb_read(32'h104, d, e);
        PRESETn = 1'b0;
        edges(2);
        chk("mid_rst_prdata", PRDATA, 32'h0);
        chk("mid_rst_irq", {31'd0, TIM_IRQ}, 32'h0);
        PRESETn = 1'b1;
        apb_read(32'h000, d, e);
        chk("post_rst_ctrl", d, 32'h0);
        apb_read(32'h004, d, e);
        chk("post_rst_psc", d, 32'h0);
        apb_read(32'h008, d, e);
        chk("post_rst_arr", d, 32'h0);
        apb_read(32'h100, d, e);
        chk("post_rst_stat", d, 32'h0);
        edges(5);
        apb_read(32'h00C, d, e);
        chk("post_rst_cnt", d, 32'h0);
        chk("post_rst_irq", {31'd0, TIM_IRQ}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
